tt_response_checker: RTL and testbench



---
 rtl/tt_check_pkg.sv | 27 ++
 rtl/tt_hold_timer.sv | 33 +++
 rtl/tt_response_checker.sv | 125 ++++++++++++
 tb/tb_tt_response_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_check_pkg.sv
// Shared types and sizing helpers for the truth-table response checker.
// Latency: none (types and constant functions only).
// Backpressure: none.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of input vectors for an n_in-input function.
    function automatic int num_vec(input int n_in);
        return 1 << n_in;
    endfunction

    // Mismatch counter width: must hold the value num_vec itself, not just num_vec-1.
    function automatic int cnt_w(input int n_in);
        return $clog2((1 << n_in) + 1);
    endfunction

    // Hold counter width; HOLD=1 still needs a 1-bit register.
    function automatic int hold_w(input int hold);
        return (hold <= 1) ? 1 : $clog2(hold);
    endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Hold-window timer: counts 0..HOLD-1 and flags the last cycle of each window.
// Latency: tick is high during the final cycle of a window; the consuming edge ends it.
// Backpressure: none; clear parks the count at 0 while the sweep is not running.
module tt_hold_timer
    import tt_check_pkg::*;
#(
    parameter int HOLD = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            W    = hold_w(HOLD);
    localparam logic [W-1:0]  LAST = W'(HOLD - 1);

    logic [W-1:0] cnt;

    // Free-running window counter, restarted on clear and at each window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/tt_response_checker.sv
// Exhaustive self-test sweep of an N_IN-input function, checked against a golden table.
// Latency: 2^N_IN*HOLD cycles from accepted start to done; all outputs registered.
// Backpressure: start is only honoured in IDLE; ignored while a sweep is in flight.
module tt_response_checker
    import tt_check_pkg::*;
#(
    parameter int                    N_IN     = 4,
    parameter int                    HOLD     = 20,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [N_IN-1:0]           vec,
    input  logic                      f,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [cnt_w(N_IN)-1:0]    err_count,
    output logic                      first_err_valid,
    output logic [N_IN-1:0]           first_err_idx,
    output logic [num_vec(N_IN)-1:0]  captured
);

    localparam int              NUM_VEC  = num_vec(N_IN);
    localparam int              CNT_W    = cnt_w(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NUM_VEC - 1);

    state_t state;
    state_t state_nxt;
    logic   tick;
    logic   sample;
    logic   mismatch;
    logic   last_vec;

    // Timer only runs during a sweep so every window starts from a clean count.
    tt_hold_timer #(.HOLD(HOLD)) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != RUN),
        .tick  (tick)
    );

    assign sample   = (state == RUN) && tick;
    assign last_vec = (vec == LAST_VEC);

    // Compare the sampled response against the golden bit for the current vector.
    always_comb begin
        mismatch = f ^ EXPECTED[vec];
    end

    // Next-state logic: one sweep per accepted start, DONE lasts a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (sample && last_vec) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Vector stepping and result capture; results persist in IDLE until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            captured        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec             <= '0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        captured        <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        captured[vec] <= f;
                        if (mismatch) begin
                            err_count <= err_count + CNT_W'(1);
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_idx   <= vec;
                            end
                        end
                        vec <= vec + N_IN'(1);
                        if (last_vec) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            // Include the final vector's own mismatch in the verdict.
                            pass <= (err_count == '0) && !mismatch;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_response_checker.sv
module tb_tt_response_checker;

    localparam int         NI           = 3;
    localparam int         HOLDS [NI]   = '{2, 1, 3};
    localparam logic [15:0] EXPS [NI]   = '{16'h6996, 16'h0000, 16'hA5C3};

    typedef struct {
        int          k;
        logic [15:0] ft;
        int          restart_at;
        logic [4:0]  ec;
        logic [3:0]  fei;
        logic        fev;
        logic        pass;
        logic [15:0] cap;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] start;
    logic [NI-1:0] f;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;
    logic [NI-1:0] pass;
    logic [NI-1:0] fev;
    logic [3:0]    vec [NI];
    logic [3:0]    fei [NI];
    logic [4:0]    ec  [NI];
    logic [15:0]   cap [NI];
    logic [15:0]   ftab [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [3:0] lv;

        // Emulated unit under test: its truth table plus a glitch in the first
        // cycle after the input changes, which must never be what gets sampled.
        always @(posedge clk) lv <= vec[g];
        assign f[g] = ftab[g][vec[g]] ^ ((HOLDS[g] > 1) && (vec[g] != lv));

        tt_response_checker #(
            .N_IN     (4),
            .HOLD     (HOLDS[g]),
            .EXPECTED (EXPS[g])
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start[g]),
            .vec             (vec[g]),
            .f               (f[g]),
            .busy            (busy[g]),
            .done            (done[g]),
            .pass            (pass[g]),
            .err_count       (ec[g]),
            .first_err_valid (fev[g]),
            .first_err_idx   (fei[g]),
            .captured        (cap[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: results follow directly from the set of differing table bits.
    task automatic model(input int k, input logic [15:0] ft, output vec_t r);
        logic [15:0] mism;
        mism  = EXPS[k] ^ ft;
        r.k   = k;
        r.ft  = ft;
        r.restart_at = -1;
        r.ec  = 5'($countones(mism));
        r.fev = (mism != 16'h0);
        r.fei = 4'h0;
        for (int i = 15; i >= 0; i--) if (mism[i]) r.fei = 4'(i);
        r.pass = (mism == 16'h0);
        r.cap  = ft;
    endtask

    task automatic check_results(input string tag, input vec_t e);
        int k = e.k;
        chk({tag, ".err_count"},       64'(ec[k]),   64'(e.ec));
        chk({tag, ".first_err_valid"}, 64'(fev[k]),  64'(e.fev));
        chk({tag, ".first_err_idx"},   64'(fei[k]),  64'(e.fei));
        chk({tag, ".pass"},            64'(pass[k]), 64'(e.pass));
        chk({tag, ".captured"},        64'(cap[k]),  64'(e.cap));
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s.k%0d.busy_done_pass_fev", tag, k),
                64'({busy[k], done[k], pass[k], fev[k]}), 64'(0));
            chk($sformatf("%s.k%0d.vec_idx_cnt", tag, k),
                64'({vec[k], fei[k], ec[k]}), 64'(0));
            chk($sformatf("%s.k%0d.captured", tag, k), 64'(cap[k]), 64'(0));
        end
    endtask

    // Results must stay frozen and the sequencer quiet while idle.
    task automatic hold_idle(input string tag, input vec_t e, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk($sformatf("%s.idle%0d.busy_done_vec", tag, c),
                64'({busy[e.k], done[e.k], vec[e.k]}), 64'(0));
        end
        check_results({tag, ".held"}, e);
    endtask

    // Called at a negedge; one start pulse, then the whole timeline is checked per cycle.
    task automatic run_sweep(input string tag, input int k, input logic [15:0] ft,
                             input int restart_at, input int abort_at);
        int         h;
        int         total;
        logic       eb;
        logic       ed;
        logic [3:0] ev;
        h     = HOLDS[k];
        total = 16 * h;
        ftab[k]  = ft;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        chk($sformatf("%s.E0.busy_done_vec", tag),
            64'({busy[k], done[k], vec[k]}), 64'({1'b1, 1'b0, 4'h0}));
        chk($sformatf("%s.E0.cleared", tag),
            64'({pass[k], fev[k], ec[k], cap[k]}), 64'(0));
        for (int n = 1; n <= total + 1; n++) begin
            start[k] = (n == restart_at);
            @(negedge clk);
            start[k] = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, ".rst_async"});
                repeat (2) @(negedge clk);
                check_all_zero({tag, ".rst_hold"});
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            eb = (n < total);
            ed = (n == total);
            ev = (n < total) ? 4'(n / h) : 4'h0;
            chk($sformatf("%s.E%0d.busy_done_vec", tag, n),
                64'({busy[k], done[k], vec[k]}), 64'({eb, ed, ev}));
        end
    endtask

    vec_t tbl [7];
    vec_t e;

    initial begin
        // Hand-derived scenarios: instance 0 is HOLD=2/6996, 1 is HOLD=1/0000, 2 is HOLD=3/A5C3.
        tbl[0] = '{k:0, ft:16'h6996, restart_at:-1, ec:5'd0,  fei:4'd0,  fev:1'b0, pass:1'b1, cap:16'h6996};
        tbl[1] = '{k:0, ft:16'h6997, restart_at:-1, ec:5'd1,  fei:4'd0,  fev:1'b1, pass:1'b0, cap:16'h6997};
        tbl[2] = '{k:1, ft:16'hFFFF, restart_at:-1, ec:5'd16, fei:4'd0,  fev:1'b1, pass:1'b0, cap:16'hFFFF};
        tbl[3] = '{k:0, ft:16'h6996, restart_at:10, ec:5'd0,  fei:4'd0,  fev:1'b0, pass:1'b1, cap:16'h6996};
        tbl[4] = '{k:2, ft:16'hA5C3, restart_at:-1, ec:5'd0,  fei:4'd0,  fev:1'b0, pass:1'b1, cap:16'hA5C3};
        tbl[5] = '{k:2, ft:16'h25C3, restart_at:-1, ec:5'd1,  fei:4'd15, fev:1'b1, pass:1'b0, cap:16'h25C3};
        tbl[6] = '{k:1, ft:16'h0900, restart_at:5,  ec:5'd2,  fei:4'd8,  fev:1'b1, pass:1'b0, cap:16'h0900};

        rst_n = 1'b0;
        start = '0;
        for (int k = 0; k < NI; k++) ftab[k] = 16'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 7; i++) begin
            run_sweep($sformatf("tbl%0d", i), tbl[i].k, tbl[i].ft, tbl[i].restart_at, -1);
            check_results($sformatf("tbl%0d", i), tbl[i]);
            hold_idle($sformatf("tbl%0d", i), tbl[i], 50);
        end

        // Reset in the middle of a sweep, then an identical sweep must reproduce the clean result.
        run_sweep("abort", 0, 16'h6996, -1, 15);
        run_sweep("rerun", 0, 16'h6996, -1, -1);
        check_results("rerun", tbl[0]);
        hold_idle("rerun", tbl[0], 5);

        for (int r = 0; r < 12; r++) begin
            int          k;
            int          ra;
            logic [15:0] ft;
            k  = int'($urandom_range(0, NI - 1));
            ft = 16'($urandom);
            if (r % 3 == 0) ft = EXPS[k] ^ (16'h1 << $urandom_range(0, 15));
            ra = int'($urandom_range(1, 16 * HOLDS[k] + 1));
            model(k, ft, e);
            run_sweep($sformatf("rnd%0d", r), k, ft, ra, -1);
            check_results($sformatf("rnd%0d", r), e);
            hold_idle($sformatf("rnd%0d", r), e, 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
